// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : MIPS instruction-fetch stage. Holds the PC and a debug-loaded
//            instruction memory, and drives the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_branch_taken,
    input  logic [DATA_WIDTH-1:0] i_branch_target,
    input  logic                  i_jump,
    input  logic [DATA_WIDTH-1:0] i_jump_target,
    input  logic                  i_imem_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_imem_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_imem_wr_data,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_instruction,
    output logic [DATA_WIDTH-1:0] o_pc_plus4,
    output logic                  o_valid,
    output logic                  o_halt
);

    localparam logic [DATA_WIDTH-1:0] c_PC_STEP   = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] c_HALT_WORD = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] c_NOP       = '0;

    logic [DATA_WIDTH-1:0] mem_q [IMEM_DEPTH];

    logic [DATA_WIDTH-1:0] pc_q,    pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc4_q,   pc4_d;
    logic                  valid_q, valid_d;
    logic                  halt_q,  halt_d;

    logic [ADDR_WIDTH-1:0] w_fetch_addr;
    logic [DATA_WIDTH-1:0] w_fetch_word;
    logic [DATA_WIDTH-1:0] w_pc_plus4;

    // Program load is independent of run state; a same-edge fetch sees the old word.
    always_ff @(posedge i_clock) begin
        if (i_imem_wr_en) begin
            mem_q[i_imem_wr_addr] <= i_imem_wr_data;
        end
    end

    assign w_fetch_addr = pc_q[ADDR_WIDTH+1:2];
    assign w_fetch_word = mem_q[w_fetch_addr];
    assign w_pc_plus4   = pc_q + c_PC_STEP;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        if (i_enable) begin
            if (halt_q) begin
                instr_d = c_NOP;
                valid_d = 1'b0;
            end else if (i_jump) begin
                pc_d    = i_jump_target;
                instr_d = c_NOP;
                valid_d = 1'b0;
            end else if (i_branch_taken) begin
                pc_d    = i_branch_target;
                instr_d = c_NOP;
                valid_d = 1'b0;
            end else if (!i_stall) begin
                instr_d = w_fetch_word;
                pc4_d   = w_pc_plus4;
                valid_d = 1'b1;
                // The PC parks on the HALT word so the debug unit sees where it stopped.
                if (w_fetch_word == c_HALT_WORD) begin
                    halt_d = 1'b1;
                end else begin
                    pc_d = w_pc_plus4;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_q    <= '0;
            instr_q <= c_NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_instruction = instr_q;
    assign o_pc_plus4    = pc4_q;
    assign o_valid       = valid_q;
    assign o_halt        = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage: directed scenarios plus a
//            randomized run against a behavioural fetch-stage model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, en, stall, br, jmp, wr_en;
    logic [31:0] bt, jt, wr_data;
    logic [7:0]  wr_addr;
    logic [31:0] o_pc, o_instruction, o_pc_plus4;
    logic        o_valid, o_halt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halt;

    always #5 clk = ~clk;

    if_stage #(.DATA_WIDTH(32), .IMEM_DEPTH(256), .ADDR_WIDTH(8)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_enable        (en),
        .i_stall         (stall),
        .i_branch_taken  (br),
        .i_branch_target (bt),
        .i_jump          (jmp),
        .i_jump_target   (jt),
        .i_imem_wr_en    (wr_en),
        .i_imem_wr_addr  (wr_addr),
        .i_imem_wr_data  (wr_data),
        .o_pc            (o_pc),
        .o_instruction   (o_instruction),
        .o_pc_plus4      (o_pc_plus4),
        .o_valid         (o_valid),
        .o_halt          (o_halt)
    );

    // Advance one clock: the model consumes the inputs present at the edge.
    task automatic step();
        logic [31:0] word;
        word = m_mem[(m_pc / 4) % 256];
        if (rst) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0;
        end else if (en) begin
            if (m_halt) begin
                m_instr = 0; m_valid = 0;
            end else if (jmp || br) begin
                m_pc = jmp ? jt : bt; m_instr = 0; m_valid = 0;
            end else if (!stall) begin
                m_instr = word; m_pc4 = m_pc + 4; m_valid = 1;
                if (word == 32'hFFFF_FFFF) m_halt = 1;
                else m_pc = m_pc + 4;
            end
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        step();
        wr_en = 0;
    endtask

    task automatic idle_inputs();
        en = 1; stall = 0; br = 0; jmp = 0; bt = 0; jt = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    endtask

    task automatic reset_and_program();
        rst = 1;
        idle_inputs();
        load(8'd0, 32'h11); load(8'd1, 32'h22); load(8'd2, 32'h33); load(8'd3, 32'h44);
        load(8'd16, 32'hAB);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        for (int i = 0; i < 256; i++) load(i[7:0], $urandom() & 32'h7FFF_FFFF);
        n_tests++;
        if (o_pc !== 32'h0 || o_instruction !== 32'h0 || o_pc_plus4 !== 32'h0 ||
            o_valid !== 1'b0 || o_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h ins=%h pc4=%h v=%b h=%b expected all zero",
                     o_pc, o_instruction, o_pc_plus4, o_valid, o_halt);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_ins [3];
        exp_ins[0] = 32'h11; exp_ins[1] = 32'h22; exp_ins[2] = 32'h33;
        reset_and_program();
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (o_instruction !== exp_ins[i] || o_pc_plus4 !== 32'(4 * (i + 1)) || o_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d]: got ins=%h pc4=%h v=%b expected ins=%h pc4=%h v=1",
                         i, o_instruction, o_pc_plus4, o_valid, exp_ins[i], 4 * (i + 1));
            end
        end
    endtask

    task automatic test_stall();
        reset_and_program();
        step(); step();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (o_instruction !== 32'h22 || o_pc !== 32'h8 || o_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got ins=%h pc=%h v=%b expected ins=22 pc=8 v=1",
                         i, o_instruction, o_pc, o_valid);
            end
        end
        stall = 0;
        step();
        n_tests++;
        if (o_instruction !== 32'h33 || o_pc !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_resume: got ins=%h pc=%h expected ins=33 pc=c", o_instruction, o_pc);
        end
    endtask

    task automatic test_branch_over_stall();
        reset_and_program();
        step(); step();
        br = 1; bt = 32'h40; stall = 1;
        step();
        br = 0; stall = 0;
        n_tests++;
        if (o_valid !== 1'b0 || o_instruction !== 32'h0 || o_pc !== 32'h40) begin
            n_fail++;
            $display("FAIL branch_flush: got v=%b ins=%h pc=%h expected v=0 ins=0 pc=40",
                     o_valid, o_instruction, o_pc);
        end
        step();
        n_tests++;
        if (o_instruction !== 32'hAB || o_pc_plus4 !== 32'h44 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_fetch: got ins=%h pc4=%h v=%b expected ins=ab pc4=44 v=1",
                     o_instruction, o_pc_plus4, o_valid);
        end
    endtask

    task automatic test_jump_priority();
        reset_and_program();
        step();
        jmp = 1; jt = 32'h8; br = 1; bt = 32'h40;
        step();
        jmp = 0; br = 0;
        n_tests++;
        if (o_pc !== 32'h8 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_priority: got pc=%h v=%b expected pc=8 v=0", o_pc, o_valid);
        end
        step();
        n_tests++;
        if (o_instruction !== 32'h33) begin
            n_fail++;
            $display("FAIL jump_fetch: got ins=%h expected ins=33", o_instruction);
        end
    endtask

    task automatic test_halt();
        reset_and_program();
        rst = 1; load(8'd2, 32'hFFFF_FFFF); rst = 0;
        step(); step(); step();
        n_tests++;
        if (o_halt !== 1'b1 || o_instruction !== 32'hFFFF_FFFF || o_valid !== 1'b1 || o_pc !== 32'h8) begin
            n_fail++;
            $display("FAIL halt_enter: got h=%b ins=%h v=%b pc=%h expected h=1 ins=ffffffff v=1 pc=8",
                     o_halt, o_instruction, o_valid, o_pc);
        end
        jmp = 1; jt = 32'h40;
        step();
        jmp = 0;
        n_tests++;
        if (o_halt !== 1'b1 || o_instruction !== 32'h0 || o_valid !== 1'b0 || o_pc !== 32'h8) begin
            n_fail++;
            $display("FAIL halt_hold: got h=%b ins=%h v=%b pc=%h expected h=1 ins=0 v=0 pc=8",
                     o_halt, o_instruction, o_valid, o_pc);
        end
        rst = 1;
        step();
        rst = 0;
        n_tests++;
        if (o_halt !== 1'b0 || o_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL halt_reset: got h=%b pc=%h expected h=0 pc=0", o_halt, o_pc);
        end
    endtask

    task automatic test_enable_write();
        reset_and_program();
        step();
        en = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin wr_en = 1; wr_addr = 8'd1; wr_data = 32'h55; end
            step();
            wr_en = 0;
            n_tests++;
            if (o_pc !== 32'h4 || o_instruction !== 32'h11 || o_pc_plus4 !== 32'h4 || o_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL enable_freeze[%0d]: got pc=%h ins=%h pc4=%h v=%b expected pc=4 ins=11 pc4=4 v=1",
                         i, o_pc, o_instruction, o_pc_plus4, o_valid);
            end
        end
        en = 1;
        step();
        n_tests++;
        if (o_instruction !== 32'h55 || o_pc !== 32'h8) begin
            n_fail++;
            $display("FAIL reenable_new_word: got ins=%h pc=%h expected ins=55 pc=8", o_instruction, o_pc);
        end
        wr_en = 1; wr_addr = 8'd2; wr_data = 32'h66;
        step();
        wr_en = 0;
        n_tests++;
        if (o_instruction !== 32'h33) begin
            n_fail++;
            $display("FAIL write_fetch_old: got ins=%h expected ins=33", o_instruction);
        end
        jmp = 1; jt = 32'h8;
        step();
        jmp = 0;
        step();
        n_tests++;
        if (o_instruction !== 32'h66) begin
            n_fail++;
            $display("FAIL write_committed: got ins=%h expected ins=66", o_instruction);
        end
    endtask

    task automatic test_random();
        reset_and_program();
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 99) < 2);
            en    = ($urandom_range(0, 99) < 90);
            stall = ($urandom_range(0, 99) < 20);
            br    = ($urandom_range(0, 99) < 10);
            jmp   = ($urandom_range(0, 99) < 8);
            bt    = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            jt    = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            wr_en = ($urandom_range(0, 99) < 15);
            wr_addr = ($urandom_range(0, 1) == 0) ? 8'((m_pc / 4) % 256) : 8'($urandom());
            wr_data = ($urandom_range(0, 99) < 3) ? 32'hFFFF_FFFF : $urandom();
            step();
            n_tests++;
            if (o_pc !== m_pc || o_instruction !== m_instr || o_pc_plus4 !== m_pc4 ||
                o_valid !== m_valid || o_halt !== m_halt) begin
                n_fail++;
                $display("FAIL random[%0d]: got pc=%h ins=%h pc4=%h v=%b h=%b expected pc=%h ins=%h pc4=%h v=%b h=%b",
                         c, o_pc, o_instruction, o_pc_plus4, o_valid, o_halt,
                         m_pc, m_instr, m_pc4, m_valid, m_halt);
            end
        end
        idle_inputs();
        rst = 0;
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0;
        rst = 1;
        idle_inputs();
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_over_stall();
        test_jump_priority();
        test_halt();
        test_enable_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
